// File: rtl/priv_pkg.sv
// Shared privilege, mstatus field and trap-FSM definitions for the trap entry/return logic.
package priv_pkg;

    localparam logic [3:0] PRIV_M = 4'b1000;
    localparam logic [3:0] PRIV_S = 4'b0010;
    localparam logic [3:0] PRIV_U = 4'b0001;

    localparam logic [1:0] MPP_M = 2'b11;
    localparam logic [1:0] MPP_S = 2'b01;
    localparam logic [1:0] MPP_U = 2'b00;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_t;

    function automatic logic [1:0] encode_priv(input logic [3:0] p);
        if (p[3])      return MPP_M;
        else if (p[1]) return MPP_S;
        else           return MPP_U;
    endfunction

    // The reserved code 2'b10 falls through to U.
    function automatic logic [3:0] decode_mpp(input logic [1:0] code);
        case (code)
            MPP_M:   return PRIV_M;
            MPP_S:   return PRIV_S;
            default: return PRIV_U;
        endcase
    endfunction

endpackage

// File: rtl/trap_entry_ctrl.sv
// Trap entry / mret / sret controller: owns privilege, trap CSRs and mstatus trap fields,
// and issues a one-cycle flush + PC redirect after each honoured event.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | accepting exceptions and mret/sret from WB
//   ST_REDIR | one-cycle flush/redirect pulse, all events ignored
module trap_entry_ctrl
    import priv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            exc_target_m,
    input  logic            exc_target_s,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] ins_pc,
    input  logic            mret,
    input  logic            sret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic            csr_write,
    input  logic [XLEN-1:0] data_csr,
    input  logic            mrw_mepc_sel,
    input  logic            mrw_mcause_sel,
    input  logic            mrw_mtval_sel,
    input  logic            srw_sepc_sel,
    input  logic            srw_scause_sel,
    input  logic            srw_stval_sel,
    input  logic            mrw_mstatus_sel,
    output logic [3:0]      priv,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] sepc,
    output logic [XLEN-1:0] scause,
    output logic [XLEN-1:0] stval,
    output logic            mie,
    output logic            mpie,
    output logic            sie,
    output logic            spie,
    output logic            spp,
    output logic [1:0]      mpp,
    output logic            trap_busy,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    trap_state_t state, state_nxt;
    logic ev_m, ev_s, ev_mret, ev_sret;
    logic wr_mepc, wr_mcause, wr_mtval, wr_sepc, wr_scause, wr_stval, wr_mstatus;
    logic [1:0] wr_mpp_val;

    // An mret/sret that loses the privilege check still occupies its priority slot.
    always_comb begin
        ev_m    = 1'b0;
        ev_s    = 1'b0;
        ev_mret = 1'b0;
        ev_sret = 1'b0;
        if (state == ST_IDLE) begin
            if (exc_target_m)        ev_m    = 1'b1;
            else if (exc_target_s)   ev_s    = 1'b1;
            else if (valid && mret)  ev_mret = priv[3];
            else if (valid && sret)  ev_sret = priv[3] | priv[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ev_m || ev_s || ev_mret || ev_sret) state_nxt = ST_REDIR;
            ST_REDIR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        trap_busy   = (state == ST_REDIR);
        pc_redirect = (state == ST_REDIR);
        flush       = (state == ST_REDIR);
    end

    assign wr_mepc    = csr_write & mrw_mepc_sel;
    assign wr_mcause  = csr_write & mrw_mcause_sel;
    assign wr_mtval   = csr_write & mrw_mtval_sel;
    assign wr_sepc    = csr_write & srw_sepc_sel;
    assign wr_scause  = csr_write & srw_scause_sel;
    assign wr_stval   = csr_write & srw_stval_sel;
    assign wr_mstatus = csr_write & mrw_mstatus_sel;
    assign wr_mpp_val = (data_csr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10)
                        ? MPP_U : data_csr[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

    // Software writes are applied first; trap/return updates below override them.
    always_ff @(posedge clk) begin
        if (rst) begin
            priv        <= PRIV_M;
            mpp         <= MPP_M;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            sie         <= 1'b0;
            spie        <= 1'b0;
            spp         <= 1'b0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            sepc        <= '0;
            scause      <= '0;
            stval       <= '0;
            redirect_pc <= '0;
        end else begin
            if (wr_mepc)   mepc   <= data_csr & ALIGN_MASK;
            if (wr_mcause) mcause <= data_csr;
            if (wr_mtval)  mtval  <= data_csr;
            if (wr_sepc)   sepc   <= data_csr & ALIGN_MASK;
            if (wr_scause) scause <= data_csr;
            if (wr_stval)  stval  <= data_csr;
            if (wr_mstatus) begin
                mie  <= data_csr[MSTATUS_MIE];
                sie  <= data_csr[MSTATUS_SIE];
                mpie <= data_csr[MSTATUS_MPIE];
                spie <= data_csr[MSTATUS_SPIE];
                spp  <= data_csr[MSTATUS_SPP];
                mpp  <= wr_mpp_val;
            end

            if (ev_m) begin
                mepc        <= ins_pc & ALIGN_MASK;
                mcause      <= exc_cause;
                mtval       <= exc_tval;
                mpie        <= mie;
                mie         <= 1'b0;
                mpp         <= encode_priv(priv);
                priv        <= PRIV_M;
                redirect_pc <= mtvec & ALIGN_MASK;
            end else if (ev_s) begin
                sepc        <= ins_pc & ALIGN_MASK;
                scause      <= exc_cause;
                stval       <= exc_tval;
                spie        <= sie;
                sie         <= 1'b0;
                spp         <= priv[1];
                priv        <= PRIV_S;
                redirect_pc <= stvec & ALIGN_MASK;
            end else if (ev_mret) begin
                priv        <= decode_mpp(mpp);
                mie         <= mpie;
                mpie        <= 1'b1;
                mpp         <= MPP_U;
                redirect_pc <= mepc;
            end else if (ev_sret) begin
                priv        <= spp ? PRIV_S : PRIV_U;
                sie         <= spie;
                spie        <= 1'b1;
                spp         <= 1'b0;
                redirect_pc <= sepc;
            end
        end
    end

endmodule

// File: doc/trap_entry_ctrl.md
Name: trap_entry_ctrl

Overview:
Consumer of the exception-delegation outputs (exc_target_m/exc_target_s/exc_cause). Performs trap entry and trap return (mret/sret). Owns:
- the current privilege register
- the trap CSRs: mepc/mcause/mtval, sepc/scause/stval
- the trap fields of mstatus: MIE, MPIE, MPP, SIE, SPIE, SPP

It drives a one-cycle pipeline flush and PC redirect to the trap vector or the saved EPC. It sits between WB and the fetch unit.

Parameters:
XLEN, 64, data/address width of all CSRs and PCs.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid  in  1  WB instruction valid; qualifies mret/sret only (exc_target_* are already valid-qualified)
exc_target_m  in  1  exception taken to M
exc_target_s  in  1  exception taken to S
exc_cause  in  XLEN  encoded cause for the current exception
exc_tval  in  XLEN  faulting address or instruction, 0 if none
ins_pc  in  XLEN  PC of the WB instruction
mret  in  1  mret retiring in WB
sret  in  1  sret retiring in WB
mtvec  in  XLEN  M trap vector (direct mode)
stvec  in  XLEN  S trap vector (direct mode)
csr_write  in  1  CSR write strobe
data_csr  in  XLEN  CSR write data
mrw_mepc_sel, mrw_mcause_sel, mrw_mtval_sel, srw_sepc_sel, srw_scause_sel, srw_stval_sel, mrw_mstatus_sel  in  1 each  CSR selects
priv  out  4  one-hot privilege: [3]=M, [1]=S, [0]=U
mepc, mcause, mtval, sepc, scause, stval  out  XLEN each  CSR read values
mie, mpie, sie, spie, spp  out  1 each  mstatus trap fields
mpp  out  2  mstatus.MPP
trap_busy  out  1  high in REDIR; upstream holds valid low
pc_redirect  out  1  one-cycle redirect strobe
redirect_pc  out  XLEN  redirect target
flush  out  1  one-cycle pipeline flush

Behaviour:
- Reset values:
  - priv=4'b1000, MPP=2'b11.
  - mie, mpie, sie, spie, spp = 0; all six XLEN CSRs = 0.
  - trap_busy, pc_redirect, flush, redirect_pc = 0; FSM state = IDLE.
- FSM has two states, IDLE and REDIR.
- In IDLE, events are evaluated with fixed priority: exc_target_m > exc_target_s > (valid&mret) > (valid&sret).
  - A winning event's register updates occur at the clock edge ending cycle T.
  - The state then goes to REDIR.
- M entry:
  - mepc <= {ins_pc[XLEN-1:2],2'b00}; mcause <= exc_cause; mtval <= exc_tval.
  - MPIE <= MIE; MIE <= 0; MPP <= encode(priv) (M=11, S=01, U=00); priv <= M.
  - redirect_pc <= {mtvec[XLEN-1:2],2'b00}.
- S entry:
  - sepc, scause and stval are loaded the same way as the M-entry CSRs.
  - SPIE <= SIE; SIE <= 0; SPP <= priv[1]; priv <= S.
  - redirect_pc <= {stvec[XLEN-1:2],2'b00}.
- mret:
  - Honoured only if priv[3]; otherwise ignored and no redirect occurs.
  - priv <= decode(MPP), where 10 decodes as U. MIE <= MPIE; MPIE <= 1; MPP <= 00.
  - redirect_pc <= mepc.
- sret:
  - Honoured only if priv[3]|priv[1].
  - priv <= SPP?S:U; SIE <= SPIE; SPIE <= 1; SPP <= 0.
  - redirect_pc <= sepc.
- REDIR (cycle T+1): trap_busy=pc_redirect=flush=1 for exactly one cycle, then IDLE unconditionally. All events in REDIR are ignored. New events are accepted from T+2.
- Latency: event at T gives redirect at T+1. CSR outputs show new values from T+1.
- CSR writes are accepted in either state.
  - mepc/sepc writes clear bits [1:0].
  - mstatus write takes MIE=d[3], SIE=d[1], MPIE=d[7], SPIE=d[5], SPP=d[8], MPP=d[12:11]; MPP value 10 is written as 00.
  - If a trap/return and a CSR write target the same register in the same cycle, the trap/return update wins.
- Both exc_target_m and exc_target_s high: M entry only; the S CSRs are untouched.
- rst asserted in REDIR: the next cycle is IDLE with all reset values; the redirect is dropped.
- Back-to-back exceptions at T and T+1: the second is ignored. Upstream guarantees it is not presented.

Decomposition:
Shared package (priv_pkg) holds:
- priv one-hot constants PRIV_M=4'b1000, PRIV_S=4'b0010, PRIV_U=4'b0001
- MPP codes 2'b11/2'b01/2'b00
- encode/decode functions
- mstatus bit indices (3,1,7,5,8,12:11)
- FSM state constants

No sub-module. One flat module with an FSM and a CSR register block.

Test Plan:
- Reset, then exc_target_m=1, exc_cause=2, ins_pc=0x8000_0104, exc_tval=0xDEAD, mtvec=0x8000_0003:
  - T+1: pc_redirect=flush=1, redirect_pc=0x8000_0000, mepc=0x8000_0104, mcause=2, mtval=0xDEAD, MPP=11, MIE=0, priv=1000.
  - T+2: strobes 0.
- From U (after mret with MPP=00), set MIE=1; exc_target_s with cause 8 and stvec=0x9000_0000:
  - priv=0010, SPP=0, SIE=0, SPIE=previous SIE, sepc=ins_pc, redirect_pc=0x9000_0000; M CSRs unchanged.
- mret with MPP=01, MPIE=1, mepc=0x1000:
  - priv=0010, MIE=1, MPIE=1, MPP=00, redirect_pc=0x1000.
- sret while priv=U:
  - No redirect and no state change.
- exc_target_m together with csr_write&mrw_mepc_sel (data 0x5555):
  - mepc=ins_pc (trap wins).
- Second exc_target_m in the REDIR cycle:
  - Ignored; exactly one flush pulse.
- rst asserted in REDIR:
  - Next cycle all outputs at reset values.
